// File: rtl/mem_lower_pkg.sv
// Shared helpers for lowered memory wrappers: address width, lane count and latency legality.
// Pure elaboration-time content; no logic is generated from this file.
`ifndef MEM_LOWER_PKG_SV
`define MEM_LOWER_PKG_SV

// Rejects any read latency the wrapper pipelines cannot build.
`define MEM_LOWER_CHECK_RL(RL) \
  if (!((RL) == 1 || (RL) == 2)) begin : g_bad_read_latency \
    $error("READ_LATENCY must be 1 or 2"); \
  end

package mem_lower_pkg;

  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int lane_cnt(input int width, input int gran);
    return width / gran;
  endfunction

endpackage

`endif

// File: rtl/mem_1r1w_masked_if.sv
// Read and write port bundle of the masked 1r1w memory; the memory is the slave side.
interface mem_1r1w_masked_if
  import mem_lower_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8
);
  localparam int AW = addr_w(DEPTH);
  localparam int MW = lane_cnt(WIDTH, MASK_GRAN);

  logic [AW-1:0]    R0_addr;
  logic             R0_en;
  logic [WIDTH-1:0] R0_data;
  logic             R0_valid;
  logic [AW-1:0]    W0_addr;
  logic             W0_en;
  logic [WIDTH-1:0] W0_data;
  logic [MW-1:0]    W0_mask;

  modport master (
    output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    input  R0_data, R0_valid
  );

  modport slave (
    input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    output R0_data, R0_valid
  );
endinterface

// File: rtl/mem_lane_merge.sv
// Combinational lane mux: each mask bit selects its lane from the new word, else the old word.
module mem_lane_merge #(
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8,
  parameter int MW        = WIDTH / MASK_GRAN
) (
  input  logic [WIDTH-1:0] i_old,
  input  logic [WIDTH-1:0] i_new,
  input  logic [MW-1:0]    i_mask,
  output logic [WIDTH-1:0] o_merged
);

  for (genvar i = 0; i < MW; i++) begin : g_lane
    assign o_merged[i*MASK_GRAN +: MASK_GRAN] =
      i_mask[i] ? i_new[i*MASK_GRAN +: MASK_GRAN] : i_old[i*MASK_GRAN +: MASK_GRAN];
  end

endmodule

// File: rtl/mem_1r1w_masked.sv
// Single-clock masked 1r1w memory with write-first forwarding and a 1- or 2-stage read pipeline.
// Array is never reset; only the read pipeline registers are.
module mem_1r1w_masked
  import mem_lower_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int WIDTH        = 64,
  parameter int MASK_GRAN    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  mem_1r1w_masked_if.slave bus
);

  localparam int AW = addr_w(DEPTH);
  localparam int MW = lane_cnt(WIDTH, MASK_GRAN);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  if (WIDTH % MASK_GRAN != 0) begin : g_bad_mask_gran
    $error("WIDTH must be a multiple of MASK_GRAN");
  end
  `MEM_LOWER_CHECK_RL(READ_LATENCY)

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic             w_wr_do;
  logic             w_fwd;
  logic [WIDTH-1:0] w_wr_old;
  logic [WIDTH-1:0] w_wr_merged;
  logic [WIDTH-1:0] w_rd_old;
  logic [WIDTH-1:0] w_fwd_merged;
  logic [WIDTH-1:0] w_rd_word;

  assign w_wr_in_range = {1'b0, bus.W0_addr} < DEPTH_C;
  assign w_rd_in_range = {1'b0, bus.R0_addr} < DEPTH_C;
  // The array has no reset, so an edge seen while reset_n is low must not commit a write.
  assign w_wr_do       = bus.W0_en && w_wr_in_range && reset_n;
  assign w_wr_old      = w_wr_in_range ? r_mem[bus.W0_addr] : '0;
  assign w_rd_old      = w_rd_in_range ? r_mem[bus.R0_addr] : '0;
  assign w_fwd         = bus.W0_en && bus.R0_en && w_wr_in_range && (bus.W0_addr == bus.R0_addr);
  assign w_rd_word     = w_fwd ? w_fwd_merged : w_rd_old;

  mem_lane_merge #(.WIDTH(WIDTH), .MASK_GRAN(MASK_GRAN), .MW(MW)) u_wr_merge (
    .i_old    (w_wr_old),
    .i_new    (bus.W0_data),
    .i_mask   (bus.W0_mask),
    .o_merged (w_wr_merged)
  );

  mem_lane_merge #(.WIDTH(WIDTH), .MASK_GRAN(MASK_GRAN), .MW(MW)) u_fwd_merge (
    .i_old    (w_rd_old),
    .i_new    (bus.W0_data),
    .i_mask   (bus.W0_mask),
    .o_merged (w_fwd_merged)
  );

  always_ff @(posedge clock) begin
    if (w_wr_do) begin
      r_mem[bus.W0_addr] <= w_wr_merged;
    end
  end

  logic [WIDTH-1:0] r_s1_dat;
  logic             r_s1_vld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_dat <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= bus.R0_en;
      if (bus.R0_en) begin
        r_s1_dat <= w_rd_word;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_stage2
    logic [WIDTH-1:0] r_s2_dat;
    logic             r_s2_vld;

    // Stage 2 only copies stage 1, so later writes never touch an in-flight word.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_s2_dat <= '0;
        r_s2_vld <= 1'b0;
      end else begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_dat <= r_s1_dat;
        end
      end
    end

    assign bus.R0_data  = r_s2_dat;
    assign bus.R0_valid = r_s2_vld;
  end else begin : g_stage1
    assign bus.R0_data  = r_s1_dat;
    assign bus.R0_valid = r_s1_vld;
  end

endmodule

// File: tb/tb_mem_1r1w_masked.sv
// Drives three memory configurations (32/L1, 32/L2, 24/L1) with identical stimulus and
// checks every cycle against a per-configuration reference model and expected-result queue.
module tb_mem_1r1w_masked;
  import mem_lower_pkg::*;

  localparam int N = 3;

  typedef struct {
    int          due;
    logic [63:0] dat;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        s_ren;
  logic [4:0]  s_raddr;
  logic        s_wen;
  logic [4:0]  s_waddr;
  logic [63:0] s_wdat;
  logic [7:0]  s_wmask;

  exp_t        q    [N][$];
  logic [63:0] mdl  [N][32];
  logic [63:0] last [N];
  logic [63:0] o_dat [N];
  logic        o_vld [N];
  int          cyc_n;
  int          n_tests;
  int          n_fail;

  mem_1r1w_masked_if #(.DEPTH(32), .WIDTH(64), .MASK_GRAN(8)) if0 ();
  mem_1r1w_masked_if #(.DEPTH(32), .WIDTH(64), .MASK_GRAN(8)) if1 ();
  mem_1r1w_masked_if #(.DEPTH(24), .WIDTH(64), .MASK_GRAN(8)) if2 ();

  assign if0.R0_en = s_ren; assign if0.R0_addr = s_raddr; assign if0.W0_en = s_wen;
  assign if0.W0_addr = s_waddr; assign if0.W0_data = s_wdat; assign if0.W0_mask = s_wmask;
  assign if1.R0_en = s_ren; assign if1.R0_addr = s_raddr; assign if1.W0_en = s_wen;
  assign if1.W0_addr = s_waddr; assign if1.W0_data = s_wdat; assign if1.W0_mask = s_wmask;
  assign if2.R0_en = s_ren; assign if2.R0_addr = s_raddr; assign if2.W0_en = s_wen;
  assign if2.W0_addr = s_waddr; assign if2.W0_data = s_wdat; assign if2.W0_mask = s_wmask;

  assign o_dat[0] = if0.R0_data; assign o_vld[0] = if0.R0_valid;
  assign o_dat[1] = if1.R0_data; assign o_vld[1] = if1.R0_valid;
  assign o_dat[2] = if2.R0_data; assign o_vld[2] = if2.R0_valid;

  mem_1r1w_masked #(.DEPTH(32), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(1)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .bus(if0.slave));
  mem_1r1w_masked #(.DEPTH(32), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(2)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .bus(if1.slave));
  mem_1r1w_masked #(.DEPTH(24), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(1)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .bus(if2.slave));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int dep_of(input int k);
    return (k == 2) ? 24 : 32;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic logic [63:0] mrg(input logic [63:0] o, input logic [63:0] n, input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Model update and scoreboard push happen at drive time, using pre-write contents.
  task automatic step();
    logic [63:0] nw;
    logic [63:0] rd;
    logic        wr_ok;
    exp_t        e;
    for (int k = 0; k < N; k++) begin
      if (reset_n) begin
        wr_ok = s_wen && (int'(s_waddr) < dep_of(k));
        nw    = wr_ok ? mrg(mdl[k][s_waddr], s_wdat, s_wmask) : 64'd0;
        if (s_ren) begin
          if (int'(s_raddr) >= dep_of(k))           rd = 64'd0;
          else if (wr_ok && (s_waddr == s_raddr))  rd = nw;
          else                                     rd = mdl[k][s_raddr];
          e.due = cyc_n + lat_of(k);
          e.dat = rd;
          q[k].push_back(e);
        end
        if (wr_ok) mdl[k][s_waddr] = nw;
      end
    end
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  task automatic drive(input logic ren, input logic [4:0] ra, input logic wen, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [7:0] wm);
    s_ren = ren; s_raddr = ra; s_wen = wen; s_waddr = wa; s_wdat = wd; s_wmask = wm;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 8'h00);
  endtask

  always @(negedge clock) begin
    for (int k = 0; k < N; k++) begin
      if (!reset_n) begin
        chk("reset_valid", k, 64'(o_vld[k]), 64'd0);
        chk("reset_data", k, o_dat[k], 64'd0);
        q[k].delete();
        last[k] = 64'd0;
      end else if (q[k].size() > 0 && q[k][0].due == cyc_n) begin
        chk("read_valid", k, 64'(o_vld[k]), 64'd1);
        chk("read_data", k, o_dat[k], q[k][0].dat);
        last[k] = q[k][0].dat;
        void'(q[k].pop_front());
      end else begin
        chk("idle_valid", k, 64'(o_vld[k]), 64'd0);
        chk("hold_data", k, o_dat[k], last[k]);
      end
    end
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc_n = 0;
    for (int k = 0; k < N; k++) last[k] = 64'd0;
    s_ren = 1'b0; s_raddr = '0; s_wen = 1'b0; s_waddr = '0; s_wdat = '0; s_wmask = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;

    // Reset held three edges, with a read and write requested that must both be ignored.
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd3, 1'b1, 5'd3, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    reset_n = 1'b1;
    idle(2);

    // Fill mem[i] = i, then stream all 32 addresses back to back.
    for (int i = 0; i < 32; i++) drive(1'b0, 5'd0, 1'b1, 5'(i), 64'(i), 8'hFF);
    for (int i = 0; i < 32; i++) drive(1'b1, 5'(i), 1'b0, 5'd0, 64'd0, 8'h00);
    idle(3);

    // Full write then read; masked overwrite; same-cycle forwarded write and read.
    drive(1'b0, 5'd0, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
    drive(1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 8'h00);
    idle(3);
    drive(1'b0, 5'd0, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    drive(1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 8'h00);
    idle(3);
    drive(1'b1, 5'd5, 1'b1, 5'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'hF0);
    idle(3);

    // Read in flight, then a write to the same word: the in-flight result keeps the old value.
    drive(1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 8'h00);
    drive(1'b0, 5'd0, 1'b1, 5'd7, 64'h1111_1111_1111_1111, 8'h03);
    drive(1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 8'h00);
    idle(3);

    // Zero mask is a no-op; address 24 is out of range only for the 24-deep instance.
    drive(1'b0, 5'd0, 1'b1, 5'd6, 64'h5555_5555_5555_5555, 8'h00);
    drive(1'b1, 5'd6, 1'b1, 5'd24, 64'h7777_7777_7777_7777, 8'hFF);
    drive(1'b1, 5'd24, 1'b0, 5'd0, 64'd0, 8'h00);
    drive(1'b1, 5'd31, 1'b1, 5'd31, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF);
    idle(3);

    // Reset pulse between edges while a read is in flight; it must never return.
    drive(1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 8'h00);
    s_ren = 1'b0;
    #2 reset_n = 1'b0;
    #4 reset_n = 1'b1;
    idle(4);

    // Reset held across an edge with a write pending: the array must not change.
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 1'b1, 5'd9, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
    reset_n = 1'b1;
    drive(1'b1, 5'd9, 1'b0, 5'd0, 64'd0, 8'h00);
    drive(1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 8'h00);
    idle(4);

    for (int k = 0; k < N; k++) chk("drained", k, 64'(q[k].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
